mem_wb_arbiter: RTL and testbench

//   Two-master Wishbone arbiter that shares the single-port on-chip SRAM slave (mem_wb) between

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_rr2.sv | 8 +
 rtl/mem_wb_arbiter.sv | 88 ++++++++
 tb/tb_mem_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, defaults and bus bundle for the mem_wb arbiter
package mem_arb_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
    logic [3:0] sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: combinational 2-way round-robin picker; on a tie the master that did not go last wins
module mem_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_wb_arbiter.sv
// mem_wb_arbiter: two-master Wishbone arbiter for the SRAM slave with tenure-locked
// round-robin grant and a stall watchdog that aborts with err
module mem_wb_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_WIDTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i
);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  logic [1:0] state, state_nxt, pick;
  logic last_grant, last_nxt, g0, g1, live, abort;
  logic [TO_WIDTH-1:0] to_cnt, to_nxt;
  wb_req_t m0, m1, mx;
  assign m0 = '{m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_sel_i, m0_wb_adr_i, m0_wb_dat_i};
  assign m1 = '{m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_sel_i, m1_wb_adr_i, m1_wb_dat_i};
  assign g0 = state == ST_GRANT0;
  assign g1 = state == ST_GRANT1;
  assign mx = g1 ? m1 : m0;
  // holder dropping cyc disconnects the slave immediately, so a late ack never leaks through
  assign live = (g0 | g1) & mx.cyc;
  assign abort = TO_EN && live && mx.stb && !s_wb_ack_i && to_cnt == TO_LAST;
  assign s_wb_cyc_o = live & ~abort;
  assign s_wb_stb_o = live & mx.stb & ~abort;
  assign s_wb_we_o = mx.we;
  assign s_wb_sel_o = mx.sel;
  assign s_wb_adr_o = mx.adr;
  assign s_wb_dat_o = mx.dat;
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = g0 & live & m0_wb_stb_i & s_wb_ack_i;
  assign m1_wb_ack_o = g1 & live & m1_wb_stb_i & s_wb_ack_i;
  assign m0_wb_err_o = g0 & abort;
  assign m1_wb_err_o = g1 & abort;
  mem_arb_rr2 u_rr (
    .req ({m1_wb_cyc_i, m0_wb_cyc_i}),
    .last(last_grant),
    .gnt (pick)
  );
  always_comb begin
    state_nxt = state == ST_IDLE ? (pick[0] ? ST_GRANT0 : pick[1] ? ST_GRANT1 : ST_IDLE) :
                live ? state :
                (g0 && m1_wb_cyc_i) ? ST_GRANT1 :
                (g1 && m0_wb_cyc_i) ? ST_GRANT0 : ST_IDLE;
    last_nxt = ((g0 | g1) && !live) ? g1 : last_grant;
    to_nxt = (TO_EN && live && mx.stb && !s_wb_ack_i && !abort) ? to_cnt + 1'b1 : '0;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
      last_grant <= 1'b1;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      last_grant <= last_nxt;
      to_cnt <= to_nxt;
    end
  end
endmodule

// File: tb/tb_mem_wb_arbiter.sv
// tb_mem_wb_arbiter: directed scenarios plus a randomized run against a tenure-level
// ownership model; a second instance with the watchdog disabled covers the long stall
module tb_mem_wb_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [3:0] m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0] s_sel;
  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
  logic z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
  logic [3:0] z_s_sel;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack),
    .m0_wb_err_o(m0_err),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack),
    .m1_wb_err_o(m1_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
    .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack)
  );

  mem_wb_arbiter #(.TIMEOUT_CYCLES(0), .TO_WIDTH(8)) dut_nowd (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_dat_o(z_m0_dat_o), .m0_wb_ack_o(z_m0_ack),
    .m0_wb_err_o(z_m0_err),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_dat_o(z_m1_dat_o), .m1_wb_ack_o(z_m1_ack),
    .m1_wb_err_o(z_m1_err),
    .s_wb_cyc_o(z_s_cyc), .s_wb_stb_o(z_s_stb), .s_wb_we_o(z_s_we), .s_wb_sel_o(z_s_sel),
    .s_wb_adr_o(z_s_adr_o), .s_wb_dat_o(z_s_dat_o), .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack)
  );

  task automatic idle_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_sel = 4'hf; m1_sel = 4'hf;
    m0_adr = '0; m0_dat = '0; m1_adr = '0; m1_dat = '0; s_dat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    m0_adr = 32'h0000_00a0; m1_adr = 32'h0000_00b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_s_cyc: got %b want 0", s_cyc); end
    checks++; if (s_adr_o !== 32'ha0) begin errors++; $display("FAIL rst_mux_m0: got %h want a0", s_adr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    m1_cyc = 1'b0; m1_stb = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    @(negedge clk); #1;
    checks++; if ({s_cyc, m0_ack} !== 2'b11) begin errors++; $display("FAIL grant0_before_rst: got %b want 11", {s_cyc, m0_ack}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({s_cyc, m0_ack} !== 2'b00) begin errors++; $display("FAIL async_rst_drop: got %b want 00", {s_cyc, m0_ack}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL idle_after_rst: got %b want 0", s_cyc); end
    @(negedge clk); #1;
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL regrant_after_rst: got %b want 1", s_cyc); end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h10;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: got %b want 0", s_cyc); end
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_stb, s_adr_o} !== {2'b11, 32'h10}) begin errors++; $display("FAIL single_connect: got %b %b %h want 1 1 10", s_cyc, s_stb, s_adr_o); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b want 0", m0_ack); end
    @(negedge clk);
    s_ack = 1'b1; s_dat = 32'hcafe_f00d;
    #1;
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL single_ack: got %b want 10", {m0_ack, m1_ack}); end
    checks++; if (m0_dat_o !== 32'hcafe_f00d || m1_dat_o !== 32'hcafe_f00d) begin errors++; $display("FAIL single_rdata: got %h/%h want cafef00d", m0_dat_o, m1_dat_o); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", s_cyc); end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_adr_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL tie_first_m0: got %b %h want 1 100", s_cyc, s_adr_o); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL tie_drop_disconnect: got %b want 0", s_cyc); end
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_adr_o} !== {1'b1, 32'h200}) begin errors++; $display("FAIL tie_handover_m1: got %b %h want 1 200", s_cyc, s_adr_o); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_adr_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL tie_rr_m0: got %b %h want 1 100", s_cyc, s_adr_o); end
    idle_inputs();
  endtask

  task automatic test_lock();
    int seen = 0;
    logic [31:0] wd;
    do_reset();
    @(negedge clk);
    m1_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h40;
      wd = $urandom;
      m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h300 + 32'(4 * k); m1_dat = wd; s_ack = 1'b1;
      #1;
      if (s_cyc && s_we && s_adr_o === 32'h300 + 32'(4 * k) && s_dat_o === wd && m1_ack && !m0_ack) seen++;
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL lock_m1_writes: got %0d want 4", seen); end
    @(negedge clk);
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_adr_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL lock_then_m0: got %b %h want 1 40", s_cyc, s_adr_o); end
    idle_inputs();
  endtask

  task automatic test_watchdog(input bit ack_at_limit);
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h20;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      s_ack = ack_at_limit && k == TO;
      #1;
      if (!ack_at_limit) begin
        checks++; if ({m0_err, s_stb, s_cyc} !== ((k == TO) ? 3'b100 : 3'b011)) begin errors++; $display("FAIL wd_cycle%0d: got err/stb/cyc %b want %b", k, {m0_err, s_stb, s_cyc}, (k == TO) ? 3'b100 : 3'b011); end
      end else if (k == TO) begin
        checks++; if ({m0_ack, m0_err, s_stb} !== 3'b101) begin errors++; $display("FAIL wd_ack_wins: got ack/err/stb %b want 101", {m0_ack, m0_err, s_stb}); end
      end
    end
    @(negedge clk);
    s_ack = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b1; m1_adr = 32'h80;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({m0_err, s_cyc, s_adr_o} !== {2'b01, 32'h20}) begin errors++; $display("FAIL wd_grant_kept: got err/cyc %b%b adr %h want 01 20", m0_err, s_cyc, s_adr_o); end
      @(negedge clk);
    end
    m0_cyc = 1'b0;
    @(negedge clk); #1;
    checks++; if ({s_cyc, s_adr_o} !== {1'b1, 32'h80}) begin errors++; $display("FAIL wd_release: got %b %h want 1 80", s_cyc, s_adr_o); end
    idle_inputs();
  endtask

  task automatic test_no_watchdog();
    int errs = 0;
    int drops = 0;
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      #1;
      if (z_m0_err) errs++;
      if (!z_s_stb) drops++;
      @(negedge clk);
    end
    checks++; if (errs !== 0) begin errors++; $display("FAIL nowd_err: got %0d pulses want 0", errs); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL nowd_stb: got %0d drops want 0", drops); end
    idle_inputs();
  endtask

  task automatic test_random();
    int owner = -1;
    bit last = 1'b1;
    int stall = 0;
    bit rc[2], rs[2];
    logic [31:0] ra[2];
    bit act, ab, ack;
    logic [5:0] got, want;
    do_reset();
    rc = '{0, 0};
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rc[i] = rc[i] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
        rs[i] = rc[i] && ($urandom_range(0, 2) != 0);
        ra[i] = $urandom;
      end
      ack = $urandom_range(0, 1) == 1;
      m0_cyc = rc[0]; m0_stb = rs[0]; m0_adr = ra[0]; m0_we = $urandom_range(0, 1) == 1; m0_dat = $urandom;
      m1_cyc = rc[1]; m1_stb = rs[1]; m1_adr = ra[1]; m1_we = $urandom_range(0, 1) == 1; m1_dat = $urandom;
      s_ack = ack; s_dat = $urandom;
      #1;
      act = owner >= 0 && rc[owner];
      ab = act && rs[owner] && !ack && stall == TO - 1;
      want = '0;
      if (act) begin
        want[5] = !ab;
        want[4] = rs[owner] && !ab;
        want[3 - owner] = ack && rs[owner];
        want[1 - owner] = ab;
      end
      got = {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err};
      checks++; if (got !== want) begin errors++; $display("FAIL rand_ctl@%0d: got cyc/stb/ack0/ack1/err0/err1 %b want %b", n, got, want); end
      if (act) begin
        checks++; if (s_adr_o !== ra[owner]) begin errors++; $display("FAIL rand_adr@%0d: got %h want %h", n, s_adr_o, ra[owner]); end
      end
      if (owner < 0) begin
        stall = 0;
        owner = (rc[0] && rc[1]) ? (last ? 0 : 1) : rc[0] ? 0 : rc[1] ? 1 : -1;
      end else if (!rc[owner]) begin
        last = owner[0];
        stall = 0;
        owner = rc[1 - owner] ? 1 - owner : -1;
      end else begin
        stall = (rs[owner] && !ack && !ab) ? stall + 1 : 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_no_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
